booth_seq_mult: RTL

- Iterative radix-4 Booth signed multiplier with a valid/ready handshake.
- Sits directly upstream of the three-operand Karatsuba compressor/combiner stage.
- Time-multiplexed replacement for the combinational booth array; one instance is reused to produce the k1, k2 and k3 partial products in sequence.
- Computes one WIDTH/2-digit product in at most WIDTH/2 cycles.

---
 rtl/booth_pkg.sv | 37 +++
 rtl/booth_seq_mult_digit_enc.sv | 35 +++
 rtl/booth_seq_mult.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// ---------------------------------------------------------------------------
// booth_pkg
//   Shared types for the iterative radix-4 Booth multiplier:
//     booth_sel_e  : partial-product selection per Booth digit
//     state_e      : multiplier FSM states
//     booth_select : maps a 3-bit multiplier triple {y[2k+1], y[2k], y[2k-1]}
//                    to its selection code
// ---------------------------------------------------------------------------
package booth_pkg;

  typedef enum logic [2:0] {
    ZERO,
    PX,
    P2X,
    M2X,
    MX
  } booth_sel_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  function automatic booth_sel_e booth_select(input logic [2:0] triple);
    booth_sel_e sel;
    case (triple)
      3'b001, 3'b010: sel = PX;
      3'b011:         sel = P2X;
      3'b100:         sel = M2X;
      3'b101, 3'b110: sel = MX;
      default:        sel = ZERO;  // 000 and 111
    endcase
    return sel;
  endfunction

endpackage : booth_pkg

// File: rtl/booth_seq_mult_digit_enc.sv
// ---------------------------------------------------------------------------
// booth_digit_enc
//   Combinational radix-4 Booth digit encoder. Selects 0, +x, +2x, -2x or -x
//   from a pre-computed x and -x (both WIDTH+1 bits, so negating the most
//   negative operand is exact) and returns it as a WIDTH+2-bit signed value.
//
//   Ports:
//     triple  in   3        {y[2k+1], y[2k], y[2k-1]}
//     x_pos   in   WIDTH+1  sign-extended multiplicand
//     x_neg   in   WIDTH+1  two's complement negation of x_pos
//     pp      out  WIDTH+2  selected partial product (signed)
// ---------------------------------------------------------------------------
module booth_digit_enc
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [2:0]       triple,
  input  logic [WIDTH:0]   x_pos,
  input  logic [WIDTH:0]   x_neg,
  output logic [WIDTH+1:0] pp
);

  always_comb begin
    pp = '0;
    case (booth_select(triple))
      PX:      pp = {x_pos[WIDTH], x_pos};
      P2X:     pp = {x_pos, 1'b0};
      M2X:     pp = {x_neg, 1'b0};
      MX:      pp = {x_neg[WIDTH], x_neg};
      default: pp = '0;
    endcase
  end

endmodule : booth_digit_enc

// File: rtl/booth_seq_mult.sv
// ---------------------------------------------------------------------------
// booth_seq_mult
//   Iterative radix-4 Booth signed multiplier with valid/ready handshake.
//   One Booth digit is processed per BUSY cycle; a product is ready after
//   WIDTH/2 BUSY cycles.
//
//   Ports:
//     clk        in   1        clock, rising edge
//     rst_n      in   1        asynchronous active-low reset
//     in_valid   in   1        operand pair x/y presented
//     in_ready   out  1        high only in IDLE
//     x          in   WIDTH    multiplicand (two's complement)
//     y          in   WIDTH    multiplier (two's complement)
//     out_valid  out  1        p holds a completed product (DONE state)
//     out_ready  in   1        consumer accepts p
//     p          out  2*WIDTH  signed product x*y
//     busy       out  1        high only in BUSY
//
//   Optional build macro BOOTH_EARLY_TERM_EN: finish as soon as all remaining
//   Booth digits are zero (latency 1..WIDTH/2 cycles, identical results).
// ---------------------------------------------------------------------------
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e               state_reg, state_next;
  logic [WIDTH:0]       x_pos_reg, x_neg_reg;
  // Multiplier with appended 0 LSB; shifted right two bits per step so the
  // current triple is always y_reg[2:0].
  logic [WIDTH:0]       y_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [2*WIDTH-1:0]   p_reg;
  logic [CW-1:0]        cnt_reg;

  logic                 accept;
  logic                 finish;
  logic                 last_step;
  logic [WIDTH:0]       x_ext;
  logic [WIDTH:0]       y_shift;
  logic [WIDTH+1:0]     pp;
  logic [2*WIDTH-1:0]   pp_ext;
  logic [2*WIDTH-1:0]   acc_sum;

  assign x_ext   = {x[WIDTH-1], x};
  // Arithmetic shift keeps the multiplier's sign in the upper bits so the
  // remaining-digit test below sees a uniform run when the rest is all sign.
  assign y_shift = {{2{y_reg[WIDTH]}}, y_reg[WIDTH:2]};

  booth_digit_enc #(
    .WIDTH (WIDTH)
  ) u_enc (
    .triple (y_reg[2:0]),
    .x_pos  (x_pos_reg),
    .x_neg  (x_neg_reg),
    .pp     (pp)
  );

  assign pp_ext  = {{(WIDTH-2){pp[WIDTH+1]}}, pp};
  assign acc_sum = acc_reg + (pp_ext << {cnt_reg, 1'b0});

  assign last_step = (cnt_reg == CW'(DIGITS - 1));

`ifdef BOOTH_EARLY_TERM_EN
  // y_shift[0] is the last consumed bit; when it and every unconsumed bit
  // agree, every remaining triple is 000 or 111.
  assign finish = last_step || (y_shift == '0) || (y_shift == '1);
`else
  assign finish = last_step;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (finish) state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_pos_reg <= '0;
      x_neg_reg <= '0;
      y_reg     <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      p_reg     <= '0;
    end else if (accept) begin
      x_pos_reg <= x_ext;
      x_neg_reg <= ~x_ext + (WIDTH+1)'(1);
      y_reg     <= {y, 1'b0};
      acc_reg   <= '0;
      cnt_reg   <= '0;
    end else if (state_reg == BUSY) begin
      acc_reg <= acc_sum;
      y_reg   <= y_shift;
      cnt_reg <= cnt_reg + CW'(1);
      if (finish) p_reg <= acc_sum;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg == BUSY);
  assign out_valid = (state_reg == DONE);
  assign p         = p_reg;

endmodule : booth_seq_mult
